// File: rtl/pinmux_pkg.sv
// Shared definitions for the pin-routing break-before-make sequencer.
// Holds the FSM state type, the default group count and the index of each
// switched pin group (matching the sw12..sw15 mode switches).
package pinmux_pkg;

    localparam int unsigned NUM_GROUPS = 4;

    // Group indices; bit position in sw_req / sel / hiz.
    localparam int unsigned GRP_PS2   = 0;  // sw12
    localparam int unsigned GRP_VGA   = 1;  // sw13, VGA / pmodC
    localparam int unsigned GRP_AUDIO = 2;  // sw14, audio / pmodB
    localparam int unsigned GRP_UART  = 3;  // sw15, USB UART / Prop Plug

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StMake
    } state_e;

endpackage

// File: rtl/pinmux_sequencer_guard_timer.sv
// guard_timer: loadable down-counter used to time the break and settle windows.
//   clock         : clock
//   reset         : synchronous active-high reset, clears the count
//   load_i        : load load_value_i this cycle (takes priority over dec_i)
//   load_value_i  : value to load
//   dec_i         : decrement by one; saturates at zero
//   zero_o        : current count is zero
module guard_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pinmux_sequencer.sv
// pinmux_sequencer: applies debounced routing-switch changes to the pad
// multiplexer selects one group at a time, tristating the group's pads for a
// guard window before the select flips and a settle window after it.
//   clock     : clock (slow_clk domain)
//   reset     : synchronous active-high reset
//   enable    : allow new transactions to start
//   sw_req    : requested select per group (debounced switch levels)
//   sel       : applied select per group
//   hiz       : force-tristate per group (at most one bit set)
//   core_hold : hold the core in reset while HOLD_GROUP is being swapped
//   busy      : transaction in progress
module pinmux_sequencer #(
    parameter int unsigned NUM_GROUPS    = pinmux_pkg::NUM_GROUPS,
    parameter int unsigned GUARD_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_GROUP    = pinmux_pkg::GRP_UART
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_GROUPS-1:0] sw_req,
    output logic [NUM_GROUPS-1:0] sel,
    output logic [NUM_GROUPS-1:0] hiz,
    output logic                  core_hold,
    output logic                  busy
);

    import pinmux_pkg::*;

    localparam int unsigned MAX_CYC = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned GRP_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    state_e                state_q, state_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic [NUM_GROUPS-1:0] sel_q, sel_d;
    logic [NUM_GROUPS-1:0] hiz_q, hiz_d;
    logic                  core_hold_q, core_hold_d;
    logic                  busy_q, busy_d;

    logic [NUM_GROUPS-1:0] pending;
    logic                  grant_valid;
    logic [GRP_W-1:0]      grant_idx;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_value;
    logic                  tmr_dec;
    logic                  tmr_zero;

    // Fixed-priority grant: lowest pending index wins, so scan high to low.
    always_comb begin
        pending     = enable ? (sw_req ^ sel_q) : '0;
        grant_valid = |pending;
        grant_idx   = '0;
        for (int i = int'(NUM_GROUPS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = GRP_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        sel_d       = sel_q;
        hiz_d       = hiz_q;
        core_hold_d = core_hold_q;
        busy_d      = busy_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d             = StBreak;
                    grp_d               = grant_idx;
                    hiz_d               = '0;
                    hiz_d[grant_idx]    = 1'b1;
                    busy_d              = 1'b1;
                    core_hold_d         = (grant_idx == GRP_W'(HOLD_GROUP));
                    tmr_load            = 1'b1;
                    tmr_value           = CNT_W'(GUARD_CYCLES - 1);
                end
            end
            StBreak: begin
                if (tmr_zero) begin
                    // Sample the live switch level: a revert during the break
                    // leaves sel unchanged and the transaction simply finishes.
                    sel_d[grp_q] = sw_req[grp_q];
                    state_d      = StMake;
                    tmr_load     = 1'b1;
                    tmr_value    = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            StMake: begin
                if (tmr_zero) begin
                    hiz_d       = '0;
                    core_hold_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tmr_dec = (state_q != StIdle);

    guard_timer #(
        .WIDTH (CNT_W)
    ) u_guard_timer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .dec_i        (tmr_dec),
        .zero_o       (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            grp_q       <= '0;
            sel_q       <= '0;
            hiz_q       <= '0;
            core_hold_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            sel_q       <= sel_d;
            hiz_q       <= hiz_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign hiz       = hiz_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pinmux_sequencer.sv
// Directed bench for pinmux_sequencer with default parameters
// (4 groups, 16 guard, 16 settle, hold on group 3).
module tb_pinmux_sequencer;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] sw_req;
    logic [3:0] sel;
    logic [3:0] hiz;
    logic       core_hold;
    logic       busy;

    int n_checks;
    int n_fail;

    // Per-cycle activity counters, cleared by clear_stats.
    int hiz_cnt [4];
    int hold_cnt;
    int multi_cnt;

    pinmux_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sw_req    (sw_req),
        .sel       (sel),
        .hiz       (hiz),
        .core_hold (core_hold),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) hiz_cnt[i] = 0;
        hold_cnt  = 0;
        multi_cnt = 0;
    endtask

    // Advance to 1 time unit after the next rising edge and record activity.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++) if (hiz[i]) hiz_cnt[i]++;
            if (core_hold) hold_cnt++;
            if ($countones(hiz) > 1) multi_cnt++;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sw_req = 4'b0000;
        step(2);
        reset  = 1'b0;
        step(2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        sw_req   = 4'b0000;
        clear_stats();

        // Reset values
        step(3);
        check_val("rst_sel", 32'(sel), 32'h0);
        check_val("rst_hiz", 32'(hiz), 32'h0);
        check_val("rst_hold", 32'(core_hold), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step(2);

        // Single change on group 0, request applied in cycle N
        sw_req = 4'b0001;
        clear_stats();
        step(1);                                    // N+1
        check_val("t1_hiz_rise", 32'(hiz), 32'h1);
        check_val("t1_busy_rise", 32'(busy), 32'h1);
        check_val("t1_sel_early", 32'(sel), 32'h0);
        step(15);                                   // N+16
        check_val("t1_sel_n16", 32'(sel), 32'h0);
        step(1);                                    // N+17
        check_val("t1_sel_n17", 32'(sel), 32'h1);
        step(15);                                   // N+32
        check_val("t1_hiz_n32", 32'(hiz), 32'h1);
        check_val("t1_busy_n32", 32'(busy), 32'h1);
        step(1);                                    // N+33
        check_val("t1_hiz_fall", 32'(hiz), 32'h0);
        check_val("t1_busy_fall", 32'(busy), 32'h0);
        check_val("t1_hold_cnt", 32'(hold_cnt), 32'd0);
        check_val("t1_hiz0_cnt", 32'(hiz_cnt[0]), 32'd32);

        // Simultaneous request on groups 1 and 3
        do_reset();
        sw_req = 4'b1010;
        clear_stats();
        step(1);                                    // M+1
        check_val("t2_hiz_g1", 32'(hiz), 32'h2);
        check_val("t2_hold_g1", 32'(core_hold), 32'h0);
        step(16);                                   // M+17
        check_val("t2_sel_g1", 32'(sel), 32'h2);
        step(16);                                   // M+33
        check_val("t2_idle_gap", 32'(busy), 32'h0);
        check_val("t2_idle_hiz", 32'(hiz), 32'h0);
        step(1);                                    // M+34
        check_val("t2_hiz_g3", 32'(hiz), 32'h8);
        check_val("t2_hold_g3", 32'(core_hold), 32'h1);
        step(16);                                   // M+50
        check_val("t2_sel_g3", 32'(sel), 32'ha);
        step(15);                                   // M+65
        check_val("t2_hold_n65", 32'(core_hold), 32'h1);
        step(1);                                    // M+66
        check_val("t2_hold_fall", 32'(core_hold), 32'h0);
        check_val("t2_busy_fall", 32'(busy), 32'h0);
        step(10);
        check_val("t2_final_sel", 32'(sel), 32'ha);
        check_val("t2_hold_cnt", 32'(hold_cnt), 32'd32);
        check_val("t2_hiz1_cnt", 32'(hiz_cnt[1]), 32'd32);
        check_val("t2_hiz3_cnt", 32'(hiz_cnt[3]), 32'd32);
        check_val("t2_multi_hiz", 32'(multi_cnt), 32'd0);

        // Revert on group 2 during BREAK
        do_reset();
        sw_req = 4'b0100;
        clear_stats();
        step(5);                                    // N+5
        sw_req = 4'b0000;
        step(12);                                   // N+17
        check_val("t3_sel_kept", 32'(sel), 32'h0);
        check_val("t3_hiz_make", 32'(hiz), 32'h4);
        step(36);
        check_val("t3_hiz2_cnt", 32'(hiz_cnt[2]), 32'd32);
        check_val("t3_sel_end", 32'(sel), 32'h0);
        check_val("t3_busy_end", 32'(busy), 32'h0);

        // enable gating
        do_reset();
        enable = 1'b0;
        sw_req = 4'b0100;
        clear_stats();
        step(20);
        check_val("t4_dis_busy", 32'(busy), 32'h0);
        check_val("t4_dis_hiz", 32'(hiz_cnt[2]), 32'd0);
        enable = 1'b1;                              // K
        step(1);                                    // K+1
        check_val("t4_en_hiz", 32'(hiz), 32'h4);
        step(20);                                   // K+21, in MAKE
        check_val("t4_make_sel", 32'(sel), 32'h4);
        enable = 1'b0;
        step(11);                                   // K+32
        check_val("t4_make_busy", 32'(busy), 32'h1);
        step(1);                                    // K+33
        check_val("t4_done_busy", 32'(busy), 32'h0);
        check_val("t4_done_hiz", 32'(hiz), 32'h0);
        enable = 1'b1;

        // Reset in the middle of a group 3 break
        do_reset();
        sw_req = 4'b1000;
        step(1);                                    // N+1
        check_val("t5_hold_rise", 32'(core_hold), 32'h1);
        step(5);                                    // N+6
        reset = 1'b1;
        step(1);                                    // N+7
        check_val("t5_rst_sel", 32'(sel), 32'h0);
        check_val("t5_rst_hiz", 32'(hiz), 32'h0);
        check_val("t5_rst_hold", 32'(core_hold), 32'h0);
        check_val("t5_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        clear_stats();
        step(1);                                    // N+8
        check_val("t5_new_hiz", 32'(hiz), 32'h8);
        check_val("t5_new_hold", 32'(core_hold), 32'h1);
        step(32);                                   // N+40
        check_val("t5_end_sel", 32'(sel), 32'h8);
        check_val("t5_end_hold", 32'(core_hold), 32'h0);
        check_val("t5_hold_cnt", 32'(hold_cnt), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
